ulpi_rx_decoder: RTL

- Downstream consumer of the ULPI data bus that ulpi_ctrl turns around to the link whenever the PHY drives dir high.
- Tracks bus ownership and classifies each received byte as turnaround, RX CMD, USB packet data or register-read data.
- Outputs registered PHY status (LineState, VbusState, ID, alt_int) and a byte stream of received USB packets with end-of-packet and error markers.
- Feeds the packet layer and the register-access path of ulpi_ctrl.

---
 rtl/ulpi_pkg.sv | 28 ++
 rtl/ulpi_rx_decoder_if.sv | 9 +
 rtl/ulpi_rx_decoder_rxcmd.sv | 55 +++++
 rtl/ulpi_rx_decoder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared types and RX CMD field layout for the ULPI receive path.
package ulpi_pkg;

   typedef enum logic [1:0] {
      ULPI_RX_STATE_IDLE,
      ULPI_RX_STATE_TURNAROUND,
      ULPI_RX_STATE_REG_DATA,
      ULPI_RX_STATE_RECEIVE
   } ulpi_rx_state_t;

   typedef enum logic [1:0] {
      ULPI_RXEVT_NONE     = 2'b00,
      ULPI_RXEVT_ACTIVE   = 2'b01,
      ULPI_RXEVT_HOSTDISC = 2'b10,
      ULPI_RXEVT_ERROR    = 2'b11
   } ulpi_rxevt_t;

   localparam int RXCMD_LINESTATE_LSB = 0;
   localparam int RXCMD_VBUS_LSB      = 2;
   localparam int RXCMD_EVENT_LSB     = 4;
   localparam int RXCMD_ID_BIT        = 6;
   localparam int RXCMD_ALT_INT_BIT   = 7;

   function automatic ulpi_rxevt_t rxcmd_event(input logic [7:0] rxcmd);
      return ulpi_rxevt_t'(rxcmd[RXCMD_EVENT_LSB +: 2]);
   endfunction

endpackage

// File: rtl/ulpi_rx_decoder_if.sv
// ULPI receive-side bus as seen by the link: dir, nxt and the 8-bit data bus.
interface ulpi_rx_if;
   logic       dir;
   logic       nxt;
   logic [7:0] data;

   modport master (output dir, output nxt, output data);
   modport slave  (input dir, input nxt, input data);
endinterface

// File: rtl/ulpi_rx_decoder_rxcmd.sv
// RX CMD field unpacking: registered PHY status, host-disconnect flag and RX CMD strobe.
module ulpi_rxcmd_decode
   import ulpi_pkg::*;
#(
   parameter logic [1:0] RXCMD_RESET_LINESTATE = 2'b01
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rxcmd_stb,
   input  logic [7:0] i_rxcmd,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus_state,
   output logic       o_id,
   output logic       o_alt_int,
   output logic       o_host_disconnect,
   output logic       o_rxcmd_valid
);

   logic [1:0] linestate_q;
   logic [1:0] vbus_state_q;
   logic       id_q;
   logic       alt_int_q;
   logic       host_disc_q;
   logic       rxcmd_valid_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         linestate_q   <= RXCMD_RESET_LINESTATE;
         vbus_state_q  <= 2'b00;
         id_q          <= 1'b0;
         alt_int_q     <= 1'b0;
         host_disc_q   <= 1'b0;
         rxcmd_valid_q <= 1'b0;
      end else begin
         rxcmd_valid_q <= i_rxcmd_stb;
         if (i_rxcmd_stb) begin
            linestate_q  <= i_rxcmd[RXCMD_LINESTATE_LSB +: 2];
            vbus_state_q <= i_rxcmd[RXCMD_VBUS_LSB +: 2];
            id_q         <= i_rxcmd[RXCMD_ID_BIT];
            alt_int_q    <= i_rxcmd[RXCMD_ALT_INT_BIT];
            // Any later RX CMD reporting a different event drops the disconnect flag.
            host_disc_q  <= (rxcmd_event(i_rxcmd) == ULPI_RXEVT_HOSTDISC);
         end
      end
   end

   assign o_linestate       = linestate_q;
   assign o_vbus_state      = vbus_state_q;
   assign o_id              = id_q;
   assign o_alt_int         = alt_int_q;
   assign o_host_disconnect = host_disc_q;
   assign o_rxcmd_valid     = rxcmd_valid_q;

endmodule

// File: rtl/ulpi_rx_decoder.sv
// ULPI receive decoder: tracks bus turnaround and splits PHY bytes into RX CMDs, packet data and register data.
module ulpi_rx_decoder
   import ulpi_pkg::*;
#(
   parameter logic [1:0] RXCMD_RESET_LINESTATE = 2'b01
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   ulpi_rx_if.slave   bus,
   input  logic       i_reg_rd_pending,
   output logic [7:0] o_reg_data,
   output logic       o_reg_data_valid,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_active,
   output logic       o_rx_eop,
   output logic       o_rx_err,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus_state,
   output logic       o_id,
   output logic       o_alt_int,
   output logic       o_host_disconnect,
   output logic       o_rxcmd_valid
);

   ulpi_rx_state_t state_q;
   ulpi_rx_state_t cur_state;
   ulpi_rxevt_t    evt;
   logic           rxcmd_stb;
   logic           pkt_end;
   logic           rx_active_q;
   logic           err_q;
   logic           rx_valid_q;
   logic           rx_eop_q;
   logic           rx_err_q;
   logic           reg_valid_q;
   logic [7:0]     rx_data_q;
   logic [7:0]     reg_data_q;

   // The first dir-high cycle is the turnaround cycle and is decoded in the cycle it appears.
   assign cur_state = (state_q == ULPI_RX_STATE_IDLE && bus.dir) ? ULPI_RX_STATE_TURNAROUND : state_q;
   assign evt       = rxcmd_event(bus.data);
   assign rxcmd_stb = (cur_state == ULPI_RX_STATE_RECEIVE) && bus.dir && !bus.nxt;
   assign pkt_end   = rx_active_q && (cur_state == ULPI_RX_STATE_RECEIVE) &&
                      (!bus.dir || (!bus.nxt && (evt == ULPI_RXEVT_NONE || evt == ULPI_RXEVT_HOSTDISC)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ULPI_RX_STATE_IDLE;
         rx_active_q <= 1'b0;
         err_q       <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_eop_q    <= 1'b0;
         rx_err_q    <= 1'b0;
         reg_valid_q <= 1'b0;
         rx_data_q   <= 8'h00;
         reg_data_q  <= 8'h00;
      end else begin
         rx_valid_q  <= 1'b0;
         rx_eop_q    <= 1'b0;
         rx_err_q    <= 1'b0;
         reg_valid_q <= 1'b0;
         case (cur_state)
            ULPI_RX_STATE_IDLE: ;
            ULPI_RX_STATE_TURNAROUND: begin
               if (bus.nxt) begin
                  rx_active_q <= 1'b1;
                  state_q     <= ULPI_RX_STATE_RECEIVE;
               end else begin
                  state_q <= i_reg_rd_pending ? ULPI_RX_STATE_REG_DATA : ULPI_RX_STATE_RECEIVE;
               end
            end
            ULPI_RX_STATE_REG_DATA: begin
               if (!bus.dir) begin
                  state_q <= ULPI_RX_STATE_IDLE;
               end else begin
                  reg_data_q  <= bus.data;
                  reg_valid_q <= 1'b1;
                  state_q     <= ULPI_RX_STATE_RECEIVE;
               end
            end
            ULPI_RX_STATE_RECEIVE: begin
               if (!bus.dir) begin
                  state_q <= ULPI_RX_STATE_IDLE;
               end else if (bus.nxt) begin
                  if (rx_active_q) begin
                     rx_data_q  <= bus.data;
                     rx_valid_q <= 1'b1;
                  end
               end else if (evt == ULPI_RXEVT_ACTIVE) begin
                  rx_active_q <= 1'b1;
               end else if (evt == ULPI_RXEVT_ERROR) begin
                  rx_active_q <= 1'b1;
                  err_q       <= 1'b1;
               end
            end
            default: state_q <= ULPI_RX_STATE_IDLE;
         endcase
         if (pkt_end) begin
            rx_eop_q    <= 1'b1;
            rx_err_q    <= err_q;
            rx_active_q <= 1'b0;
            err_q       <= 1'b0;
         end
      end
   end

   ulpi_rxcmd_decode #(
      .RXCMD_RESET_LINESTATE (RXCMD_RESET_LINESTATE)
   ) u_rxcmd (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_rxcmd_stb       (rxcmd_stb),
      .i_rxcmd           (bus.data),
      .o_linestate       (o_linestate),
      .o_vbus_state      (o_vbus_state),
      .o_id              (o_id),
      .o_alt_int         (o_alt_int),
      .o_host_disconnect (o_host_disconnect),
      .o_rxcmd_valid     (o_rxcmd_valid)
   );

   assign o_reg_data       = reg_data_q;
   assign o_reg_data_valid = reg_valid_q;
   assign o_rx_data        = rx_data_q;
   assign o_rx_valid       = rx_valid_q;
   assign o_rx_active      = rx_active_q;
   assign o_rx_eop         = rx_eop_q;
   assign o_rx_err         = rx_err_q;

endmodule
